// File: rtl/gps_track_pkg.sv
// Shared tracking-loop definitions: width defaults and the saturation limits
// used by the correlators and the loop-filter blocks.
package gps_track_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 3;
  localparam int DEFAULT_ACC_WIDTH   = 19;
  localparam int DEFAULT_NUM_TAPS    = 3;
  localparam int DEFAULT_TAP_SPACING = 1;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  // Largest value representable in a signed field of the given width.
  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed field of the given width.
  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/multitap_subchannel_correlator_tap.sv
// One correlator tap: saturating accumulate of +/-data with a sticky overflow
// flag, latched into the result registers and cleared on dump.
module correlator_tap
  import gps_track_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_valid,
  input  logic                         dump,
  input  logic                         code_bit,
  input  logic signed [DATA_WIDTH-1:0] data,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  result,
  output logic                         result_sat
);

  localparam logic signed [ACC_WIDTH:0] ACC_MAX = (ACC_WIDTH+1)'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0] ACC_MIN = (ACC_WIDTH+1)'(sat_min(ACC_WIDTH));

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, result_q, result_d, acc_new;
  logic                        sat_q, sat_d, result_sat_q, result_sat_d, sat_new;
  logic signed [DATA_WIDTH:0]  prod;
  logic signed [ACC_WIDTH:0]   sum;

  always_comb begin
    // One extra bit so that negating the most negative sample cannot wrap.
    prod = code_bit ? $signed({data[DATA_WIDTH-1], data})
                    : -$signed({data[DATA_WIDTH-1], data});
    sum  = $signed({acc_q[ACC_WIDTH-1], acc_q})
         + $signed({{(ACC_WIDTH-DATA_WIDTH){prod[DATA_WIDTH]}}, prod});

    acc_new = acc_q;
    sat_new = sat_q;
    if (sample_valid) begin
      if (sum > ACC_MAX) begin
        acc_new = ACC_MAX[ACC_WIDTH-1:0];
        sat_new = 1'b1;
      end else if (sum < ACC_MIN) begin
        acc_new = ACC_MIN[ACC_WIDTH-1:0];
        sat_new = 1'b1;
      end else begin
        acc_new = sum[ACC_WIDTH-1:0];
      end
    end

    acc_d        = acc_new;
    sat_d        = sat_new;
    result_d     = result_q;
    result_sat_d = result_sat_q;
    if (dump) begin
      result_d     = acc_new;
      result_sat_d = sat_new;
      acc_d        = '0;
      sat_d        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      sat_q        <= 1'b0;
      result_q     <= '0;
      result_sat_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      result_q     <= result_d;
      result_sat_q <= result_sat_d;
    end
  end

  assign acc        = acc_q;
  assign result     = result_q;
  assign result_sat = result_sat_q;

endmodule

// File: rtl/multitap_subchannel.sv
// Multi-tap tracking correlator: code delay line, sample counter and input
// pipeline stage feeding NUM_TAPS saturating correlator taps.
module multitap_subchannel
  import gps_track_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH   = DEFAULT_ACC_WIDTH,
  parameter int NUM_TAPS    = DEFAULT_NUM_TAPS,
  parameter int TAP_SPACING = DEFAULT_TAP_SPACING,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sample_valid,
  input  logic signed [DATA_WIDTH-1:0]    data,
  input  logic                            ca_bit,
  input  logic                            dump,
  output logic [NUM_TAPS*ACC_WIDTH-1:0]   accumulator,
  output logic [NUM_TAPS*ACC_WIDTH-1:0]   result,
  output logic [NUM_TAPS-1:0]             result_sat,
  output logic [COUNT_WIDTH-1:0]          result_count,
  output logic                            result_valid
);

  localparam int LINE_LEN = (NUM_TAPS - 1) * TAP_SPACING + 1;
  localparam int HIST_W   = (LINE_LEN > 1) ? LINE_LEN - 1 : 1;

  // Past code bits only; the current ca_bit is spliced in as element 0.
  logic [HIST_W-1:0]           hist_q, hist_d;
  logic [HIST_W:0]             line_full;
  logic [NUM_TAPS-1:0]         code_q, code_d;
  logic                        s1_valid_q, s1_dump_q;
  logic signed [DATA_WIDTH-1:0] s1_data_q;
  logic [COUNT_WIDTH-1:0]      count_q, count_d, count_inc;
  logic [COUNT_WIDTH-1:0]      result_count_q, result_count_d;
  logic                        result_valid_q;

  assign line_full = {hist_q, ca_bit};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      assign code_d[gi] = line_full[gi*TAP_SPACING];

      correlator_tap #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_tap (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (s1_valid_q),
        .dump         (s1_dump_q),
        .code_bit     (code_q[gi]),
        .data         (s1_data_q),
        .acc          (accumulator[gi*ACC_WIDTH +: ACC_WIDTH]),
        .result       (result[gi*ACC_WIDTH +: ACC_WIDTH]),
        .result_sat   (result_sat[gi])
      );
    end
  endgenerate

  always_comb begin
    hist_d         = sample_valid ? line_full[HIST_W-1:0] : hist_q;
    count_inc      = (&count_q) ? count_q : count_q + 1'b1;
    count_d        = s1_valid_q ? count_inc : count_q;
    result_count_d = result_count_q;
    // A sample arriving with the dump belongs to the closing period.
    if (s1_dump_q) begin
      result_count_d = count_d;
      count_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q         <= '0;
      code_q         <= '0;
      s1_valid_q     <= 1'b0;
      s1_dump_q      <= 1'b0;
      s1_data_q      <= '0;
      count_q        <= '0;
      result_count_q <= '0;
      result_valid_q <= 1'b0;
    end else begin
      hist_q         <= hist_d;
      code_q         <= code_d;
      s1_valid_q     <= sample_valid;
      s1_dump_q      <= dump;
      s1_data_q      <= data;
      count_q        <= count_d;
      result_count_q <= result_count_d;
      result_valid_q <= s1_dump_q;
    end
  end

  assign result_count = result_count_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_multitap_subchannel.sv
// Directed and random stimulus against a behavioural correlator model; every
// output is compared each cycle against the model's expectation.
module tb_multitap_subchannel;

  localparam int DW = 3;
  localparam int AW = 6;
  localparam int NT = 3;
  localparam int TS = 2;
  localparam int CW = 4;
  localparam int L  = (NT - 1) * TS + 1;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));
  localparam int CMAX = (1 << CW) - 1;

  logic                     clk = 1'b0;
  logic                     reset, sample_valid, ca_bit, dump;
  logic signed [DW-1:0]     data;
  logic [NT*AW-1:0]         accumulator, result;
  logic [NT-1:0]            result_sat;
  logic [CW-1:0]            result_count;
  logic                     result_valid;

  always #5 clk = ~clk;

  multitap_subchannel #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_TAPS(NT), .TAP_SPACING(TS), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .data(data),
    .ca_bit(ca_bit), .dump(dump), .accumulator(accumulator), .result(result),
    .result_sat(result_sat), .result_count(result_count), .result_valid(result_valid)
  );

  typedef struct {
    logic [NT*AW-1:0] acc;
    logic [NT*AW-1:0] res;
    logic [NT-1:0]    rsat;
    logic [CW-1:0]    rcnt;
    logic             rv;
  } snap_t;

  int    checks = 0;
  int    passed = 0;
  int    cycle  = 0;
  int    m_acc[NT];
  int    m_res[NT];
  bit    m_sat[NT];
  bit    m_rsat[NT];
  int    m_cnt, m_rcnt;
  bit    hist[$];
  snap_t pending;

  function automatic snap_t zero_snap();
    snap_t s;
    s.acc = '0; s.res = '0; s.rsat = '0; s.rcnt = '0; s.rv = 1'b0;
    return s;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NT; k++) begin
      m_acc[k] = 0; m_res[k] = 0; m_sat[k] = 0; m_rsat[k] = 0;
    end
    m_cnt = 0; m_rcnt = 0;
    hist.delete();
  endfunction

  // Correlate one input cycle; returns what the outputs should show two edges later.
  function automatic snap_t model_step(input bit v, input int d, input bit c, input bit dmp);
    snap_t s;
    if (v) begin
      hist.push_front(c);
      if (hist.size() > L) void'(hist.pop_back());
      for (int k = 0; k < NT; k++) begin
        int idx  = k * TS;
        bit code = (idx < hist.size()) ? hist[idx] : 1'b0;
        int sum  = m_acc[k] + (code ? d : -d);
        if (sum > AMAX) begin sum = AMAX; m_sat[k] = 1; end
        if (sum < AMIN) begin sum = AMIN; m_sat[k] = 1; end
        m_acc[k] = sum;
      end
      if (m_cnt < CMAX) m_cnt++;
    end
    if (dmp) begin
      for (int k = 0; k < NT; k++) begin
        m_res[k] = m_acc[k]; m_rsat[k] = m_sat[k];
        m_acc[k] = 0; m_sat[k] = 0;
      end
      m_rcnt = m_cnt; m_cnt = 0;
    end
    for (int k = 0; k < NT; k++) begin
      s.acc[k*AW +: AW] = m_acc[k][AW-1:0];
      s.res[k*AW +: AW] = m_res[k][AW-1:0];
      s.rsat[k]         = m_rsat[k];
    end
    s.rcnt = m_rcnt[CW-1:0];
    s.rv   = dmp;
    return s;
  endfunction

  task automatic check_outputs(input snap_t e);
    checks++;
    assert (accumulator === e.acc) passed++;
    else $error("FAIL accumulator cyc=%0d got=%h want=%h", cycle, accumulator, e.acc);
    checks++;
    assert (result === e.res) passed++;
    else $error("FAIL result cyc=%0d got=%h want=%h", cycle, result, e.res);
    checks++;
    assert (result_sat === e.rsat) passed++;
    else $error("FAIL result_sat cyc=%0d got=%b want=%b", cycle, result_sat, e.rsat);
    checks++;
    assert (result_count === e.rcnt) passed++;
    else $error("FAIL result_count cyc=%0d got=%0d want=%0d", cycle, result_count, e.rcnt);
    checks++;
    assert (result_valid === e.rv) passed++;
    else $error("FAIL result_valid cyc=%0d got=%b want=%b", cycle, result_valid, e.rv);
  endtask

  task automatic step(input bit rst, input bit v, input int d, input bit c, input bit dmp);
    snap_t s;
    reset        = rst;
    sample_valid = v;
    data         = d[DW-1:0];
    ca_bit       = c;
    dump         = dmp;
    if (rst) begin
      model_clear();
      s       = zero_snap();
      pending = zero_snap();
    end else begin
      s = model_step(v, d, c, dmp);
    end
    @(posedge clk);
    #1;
    cycle++;
    check_outputs(pending);
    pending = s;
  endtask

  task automatic run_samples(input int n, input int d, input bit c, input bit dump_last);
    for (int i = 0; i < n; i++) step(0, 1, d, c, dump_last && (i == n - 1));
  endtask

  initial begin
    model_clear();
    pending = zero_snap();
    reset = 1; sample_valid = 0; data = '0; ca_bit = 0; dump = 0;

    // Reset with active inputs, which must be ignored.
    step(1, 1, 3, 1, 1);
    step(1, 0, 0, 0, 0);
    // Dump with nothing integrated, then a back-to-back dump.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Prime the delay line with ones, close it, then 10 samples of +3.
    run_samples(5, 3, 1, 1);
    run_samples(10, 3, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Single code pulse amid zeros, unit data: taps see it 0/2/4 samples apart.
    run_samples(6, 1, 0, 0);
    run_samples(1, 1, 1, 0);
    run_samples(7, 1, 0, 1);
    step(0, 0, 0, 0, 0);

    // Saturation, then a one-sample period that must clear the sticky flags.
    run_samples(12, 3, 1, 1);
    run_samples(1, 3, 1, 1);
    step(0, 0, 0, 0, 0);

    // Most negative sample against a zero code chip.
    run_samples(6, -4, 0, 1);
    step(0, 0, 0, 0, 0);

    // Long period saturates both the sample counter and the accumulators.
    run_samples(20, -4, 1, 1);
    step(0, 0, 0, 0, 0);

    // Sample arriving the cycle after a dump opens the next period.
    step(0, 1, 2, 1, 1);
    step(0, 1, -3, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Random traffic with occasional dumps.
    for (int i = 0; i < 400; i++) begin
      bit v   = ($urandom_range(0, 3) != 0);
      int d   = int'($urandom_range(0, 7)) - 4;
      bit c   = $urandom_range(0, 1) == 1;
      bit dmp = ($urandom_range(0, 15) == 0);
      step(0, v, d, c, dmp);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    // Reset in the middle of a period, then a fresh period from zero.
    run_samples(5, 2, 1, 0);
    step(1, 1, 3, 1, 1);
    run_samples(4, -2, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
